// File: rtl/mem_arbiter_if.sv
// Cache-to-memory bus bundle for mem_arbiter: I-cache read port, D-cache read/write port, main-memory port.
interface mem_arbiter_if #(
  parameter int unsigned s_line = 256
);
  logic              i_mem_read;
  logic [31:0]       i_mem_address;
  logic [s_line-1:0] i_mem_rdata;
  logic              i_mem_resp;

  logic              d_mem_read;
  logic              d_mem_write;
  logic [31:0]       d_mem_address;
  logic [s_line-1:0] d_mem_wdata;
  logic [s_line-1:0] d_mem_rdata;
  logic              d_mem_resp;

  logic              m_mem_read;
  logic              m_mem_write;
  logic [31:0]       m_mem_address;
  logic [s_line-1:0] m_mem_wdata;
  logic [s_line-1:0] m_mem_rdata;
  logic              m_mem_resp;

  // Arbiter side
  modport slave (
    input  i_mem_read, i_mem_address,
    output i_mem_rdata, i_mem_resp,
    input  d_mem_read, d_mem_write, d_mem_address, d_mem_wdata,
    output d_mem_rdata, d_mem_resp,
    output m_mem_read, m_mem_write, m_mem_address, m_mem_wdata,
    input  m_mem_rdata, m_mem_resp
  );

  // Caches plus main memory side
  modport master (
    output i_mem_read, i_mem_address,
    input  i_mem_rdata, i_mem_resp,
    output d_mem_read, d_mem_write, d_mem_address, d_mem_wdata,
    input  d_mem_rdata, d_mem_resp,
    input  m_mem_read, m_mem_write, m_mem_address, m_mem_wdata,
    output m_mem_rdata, m_mem_resp
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (I-cache / D-cache) arbiter onto a single main-memory port, with
// alternating priority, zero added response latency, a watchdog and a sticky error flag.
module mem_arbiter #(
  parameter int unsigned s_line  = 256,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           rst,
  mem_arbiter_if.slave   bus,
  output logic           err
);
  localparam int unsigned WD_W = 8;

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;
  typedef enum logic {GRANT_I, GRANT_D} grant_t;

  state_t            state, state_nxt;
  grant_t            last_grant, last_grant_nxt;
  logic [WD_W-1:0]   wd, wd_nxt, wd_inc;
  logic              err_nxt;
  logic              i_pend, d_pend, d_conflict;
  logic [s_line-1:0] rdata;

  assign i_pend     = bus.i_mem_read;
  assign d_pend     = bus.d_mem_read | bus.d_mem_write;
  assign d_conflict = bus.d_mem_read & bus.d_mem_write;
  assign wd_inc     = (wd == {WD_W{1'b1}}) ? wd : wd + WD_W'(1);

  // Read data is a straight pass-through to both caches
  assign rdata           = bus.m_mem_rdata;
  assign bus.i_mem_rdata = rdata;
  assign bus.d_mem_rdata = rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= GRANT_I;
      wd         <= '0;
      err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      wd         <= wd_nxt;
      err        <= err_nxt;
    end
  end

  always_comb begin
    state_nxt         = state;
    last_grant_nxt    = last_grant;
    wd_nxt            = wd;
    err_nxt           = err | d_conflict;
    bus.m_mem_read    = 1'b0;
    bus.m_mem_write   = 1'b0;
    bus.m_mem_address = '0;
    bus.m_mem_wdata   = '0;
    bus.i_mem_resp    = 1'b0;
    bus.d_mem_resp    = 1'b0;

    case (state)
      IDLE: begin
        if (bus.m_mem_resp) err_nxt = 1'b1;
        // D wins a tie unless it was the last side served
        if (d_pend && (!i_pend || last_grant == GRANT_I)) begin
          state_nxt      = SERVE_D;
          last_grant_nxt = GRANT_D;
          wd_nxt         = '0;
        end else if (i_pend) begin
          state_nxt      = SERVE_I;
          last_grant_nxt = GRANT_I;
          wd_nxt         = '0;
        end
      end

      SERVE_I: begin
        bus.m_mem_read    = bus.i_mem_read;
        bus.m_mem_address = bus.i_mem_address;
        bus.i_mem_resp    = bus.m_mem_resp;
        if (!bus.i_mem_read) err_nxt = 1'b1;
      end

      SERVE_D: begin
        bus.m_mem_read    = bus.d_mem_read;
        bus.m_mem_write   = bus.d_mem_write;
        bus.m_mem_address = bus.d_mem_address;
        bus.m_mem_wdata   = bus.d_mem_wdata;
        bus.d_mem_resp    = bus.m_mem_resp;
        if (!d_pend) err_nxt = 1'b1;
      end

      default: state_nxt = IDLE;
    endcase

    // Shared completion and watchdog handling for both serve states
    if (state == SERVE_I || state == SERVE_D) begin
      if (bus.m_mem_resp) begin
        state_nxt = IDLE;
      end else begin
        wd_nxt = wd_inc;
        if (wd_inc == WD_W'(TIMEOUT)) err_nxt = 1'b1;
      end
    end
  end
endmodule
